// File: rtl/fp_seq_pkg.sv
// Shared definitions for the sequential floating-point multiplier: FSM states,
// exponent bias and packed-word field extraction helpers.
package fp_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MULT,
        S_NORM,
        S_PACK
    } fp_state_t;

    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Helpers take the word zero-extended to 64 bits so one body serves every format.
    function automatic logic get_sign(input logic [63:0] word, input int exp_w, input int man_w);
        return word[exp_w + man_w];
    endfunction

    function automatic logic [63:0] get_exp(input logic [63:0] word, input int exp_w, input int man_w);
        return (word >> man_w) & ((64'd1 << exp_w) - 64'd1);
    endfunction

    function automatic logic [63:0] get_frac(input logic [63:0] word, input int man_w);
        return word & ((64'd1 << man_w) - 64'd1);
    endfunction

endpackage

// File: rtl/fp_seq_mant_mul.sv
// Radix-2 shift-and-add mantissa multiplier: one partial product per step,
// product available after MAN_W+1 steps. OUT_W selects how many top bits are exposed.
module fp_seq_mant_mul
    import fp_seq_pkg::*;
#(
    parameter int MAN_W = 23,
    parameter int OUT_W = 2 * (MAN_W + 1)
) (
    input  logic               clk,
    input  logic               load,
    input  logic               step,
    input  logic [MAN_W:0]     mcand,
    input  logic [MAN_W:0]     mplier,
    output logic [OUT_W-1:0]   product
);

    localparam int N = MAN_W + 1;

    logic [N-1:0]   mcand_q, mcand_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N:0]     upper_sum;

    // Multiplier sits in the low half and is consumed LSB-first as the accumulator shifts right.
    always_comb begin
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        upper_sum = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
        if (load) begin
            mcand_d = mcand;
            acc_d   = {{N{1'b0}}, mplier};
        end else if (step) begin
            acc_d = {upper_sum, acc_q[N-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        mcand_q <= mcand_d;
        acc_q   <= acc_d;
    end

    assign product = acc_q[2*N-1 -: OUT_W];

endmodule

// File: rtl/fp_seq_multiplier.sv
// Sequential IEEE-style multiplier (flush-to-zero, fixed MAN_W+4 cycle latency).
// Define FP_SEQ_MUL_RNE_EN for round-to-nearest-even; otherwise the fraction is truncated.
module fp_seq_multiplier
    import fp_seq_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 of,
    output logic                 uf
);

    localparam int W = EXP_W + MAN_W + 1;
`ifdef FP_SEQ_MUL_RNE_EN
    localparam int P_W = 2 * (MAN_W + 1);
`else
    localparam int P_W = MAN_W + 2;
`endif
    localparam int KEEP_W = P_W - 2;
    localparam int CNT_W  = $clog2(MAN_W + 1);

    localparam logic signed [EXP_W+1:0] BIAS_E = (EXP_W+2)'(exp_bias(EXP_W));
    localparam logic signed [EXP_W+1:0] E_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);
    localparam logic signed [EXP_W+1:0] E_ONE  = (EXP_W+2)'(1);
    localparam logic signed [EXP_W+1:0] E_ZERO = '0;

    fp_state_t               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    done_q, done_d, of_q, of_d, uf_q, uf_d;
    logic [W-1:0]            result_q, result_d;
    logic [W-1:0]            a_q, a_d, b_q, b_d;
    logic                    sign_q, sign_d, zero_q, zero_d, inf_q, inf_d;
    logic signed [EXP_W+1:0] exp_q, exp_d, exp_fin;
    logic [KEEP_W-1:0]       norm_q, norm_d;
`ifdef FP_SEQ_MUL_RNE_EN
    logic                    lost_q, lost_d;
    logic [MAN_W:0]          rounded;
`endif
    logic [EXP_W-1:0]        exp_a, exp_b;
    logic [MAN_W-1:0]        frac_a, frac_b, frac_fin;
    logic                    mul_load, mul_step;
    logic [P_W-1:0]          product;
    logic [W+1:0]            packed_w;

`ifdef FP_SEQ_MUL_RNE_EN
    function automatic logic rne_inc(input logic lsb, input logic guard, input logic sticky);
        return guard & (sticky | lsb);
    endfunction
`endif

    // Returns {of, uf, word}; special operands take priority over range checks.
    function automatic logic [W+1:0] sat_pack(input logic sgn, input logic signed [EXP_W+1:0] e,
                                              input logic [MAN_W-1:0] f, input logic zero,
                                              input logic inf);
        if (zero)
            return '0;
        else if (inf || e >= E_MAX)
            return {2'b10, sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (e <= E_ZERO)
            return {2'b01, {W{1'b0}}};
        else
            return {2'b00, sgn, e[EXP_W-1:0], f};
    endfunction

    assign exp_a  = EXP_W'(get_exp(64'(a_q), EXP_W, MAN_W));
    assign exp_b  = EXP_W'(get_exp(64'(b_q), EXP_W, MAN_W));
    assign frac_a = MAN_W'(get_frac(64'(a_q), MAN_W));
    assign frac_b = MAN_W'(get_frac(64'(b_q), MAN_W));

    fp_seq_mant_mul #(
        .MAN_W (MAN_W),
        .OUT_W (P_W)
    ) u_mant_mul (
        .clk     (clk),
        .load    (mul_load),
        .step    (mul_step),
        .mcand   ({1'b1, frac_a}),
        .mplier  ({1'b1, frac_b}),
        .product (product)
    );

    always_comb begin
`ifdef FP_SEQ_MUL_RNE_EN
        rounded  = {1'b0, norm_q[KEEP_W-1 -: MAN_W]}
                 + {{MAN_W{1'b0}}, rne_inc(norm_q[MAN_W], norm_q[MAN_W-1],
                                           (|norm_q[MAN_W-2:0]) | lost_q)};
        frac_fin = rounded[MAN_W-1:0];
        exp_fin  = rounded[MAN_W] ? exp_q + E_ONE : exp_q;
`else
        frac_fin = norm_q;
        exp_fin  = exp_q;
`endif
        packed_w = sat_pack(sign_q, exp_fin, frac_fin, zero_q, inf_q);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        of_d     = of_q;
        uf_d     = uf_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        zero_d   = zero_q;
        inf_d    = inf_q;
        exp_d    = exp_q;
        norm_d   = norm_q;
`ifdef FP_SEQ_MUL_RNE_EN
        lost_d   = lost_q;
`endif
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                mul_load = 1'b1;
                sign_d   = get_sign(64'(a_q), EXP_W, MAN_W) ^ get_sign(64'(b_q), EXP_W, MAN_W);
                exp_d    = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_E;
                zero_d   = (exp_a == '0) || (exp_b == '0);
                inf_d    = (&exp_a) || (&exp_b);
                cnt_d    = '0;
                state_d  = S_MULT;
            end
            S_MULT: begin
                mul_step = 1'b1;
                if (cnt_q == CNT_W'(MAN_W))
                    state_d = S_NORM;
                else
                    cnt_d = cnt_q + CNT_W'(1);
            end
            S_NORM: begin
                // Drop the leading one; a product >= 2.0 also bumps the exponent.
                norm_d  = product[P_W-1] ? product[P_W-2:1] : product[P_W-3:0];
                exp_d   = exp_q + (product[P_W-1] ? E_ONE : E_ZERO);
`ifdef FP_SEQ_MUL_RNE_EN
                lost_d  = product[P_W-1] & product[0];
`endif
                state_d = S_PACK;
            end
            S_PACK: begin
                {of_d, uf_d, result_d} = packed_w;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            of_q     <= 1'b0;
            uf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            of_q     <= of_d;
            uf_q     <= uf_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        sign_q <= sign_d;
        zero_q <= zero_d;
        inf_q  <= inf_d;
        exp_q  <= exp_d;
        norm_q <= norm_d;
`ifdef FP_SEQ_MUL_RNE_EN
        lost_q <= lost_d;
`endif
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign of     = of_q;
    assign uf     = uf_q;

endmodule

// File: tb/tb_fp_seq_multiplier.sv
// Directed-vector bench for fp_seq_multiplier: single precision plus a half-precision instance.
module tb_fp_seq_multiplier;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] in_a, in_b;
    logic        busy, done, of, uf;
    logic [31:0] result;

    logic        h_start;
    logic [15:0] h_a, h_b;
    logic        h_busy, h_done, h_of, h_uf;
    logic [15:0] h_result;

    int n_checks;
    int n_fail;

    fp_seq_multiplier dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .in_a   (in_a),
        .in_b   (in_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .of     (of),
        .uf     (uf)
    );

    fp_seq_multiplier #(.EXP_W(5), .MAN_W(10)) dut_half (
        .clk    (clk),
        .reset  (reset),
        .start  (h_start),
        .in_a   (h_a),
        .in_b   (h_b),
        .busy   (h_busy),
        .done   (h_done),
        .result (h_result),
        .of     (h_of),
        .uf     (h_uf)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic o, output logic u,
                          output int cyc);
        @(negedge clk);
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        res = result;
        o   = of;
        u   = uf;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, of, uf} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/done/of/uf=%b required 0000", {busy, done, of, uf});
        end
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_result: got %h required 00000000", result);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_vectors;
        logic [31:0] res;
        logic        o, u;
        int          cyc;
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic [31:0] vr [7];
        logic [1:0]  vf [7];
        va[0] = 32'h3F800000; vb[0] = 32'h4EA0C8E4; vr[0] = 32'h4EA0C8E4; vf[0] = 2'b00;
        va[1] = 32'hC3818000; vb[1] = 32'hC3818000; vr[1] = 32'h47830480; vf[1] = 2'b00;
        va[2] = 32'hCE8EF06B; vb[2] = 32'h00000000; vr[2] = 32'h00000000; vf[2] = 2'b00;
        va[3] = 32'h7F7FFFF0; vb[3] = 32'h41A00000; vr[3] = 32'h7F800000; vf[3] = 2'b10;
        va[4] = 32'hFF7FFFF0; vb[4] = 32'h41A00000; vr[4] = 32'hFF800000; vf[4] = 2'b10;
        va[5] = 32'h00800000; vb[5] = 32'h00800000; vr[5] = 32'h00000000; vf[5] = 2'b01;
        va[6] = 32'h7F800000; vb[6] = 32'h3F800000; vr[6] = 32'h7F800000; vf[6] = 2'b10;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], res, o, u, cyc);
            n_checks++;
            if (res !== vr[i]) begin
                n_fail++;
                $display("FAIL vec%0d_result: got %h required %h", i, res, vr[i]);
            end
            n_checks++;
            if ({o, u} !== vf[i]) begin
                n_fail++;
                $display("FAIL vec%0d_flags: of/uf=%b required %b", i, {o, u}, vf[i]);
            end
            n_checks++;
            if (cyc != 27) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got %0d cycles required 27", i, cyc);
            end
        end
    endtask

    task automatic test_rounding;
        logic [31:0] res, exp_r;
        logic        o, u;
        int          cyc;
`ifdef FP_SEQ_MUL_RNE_EN
        exp_r = 32'h40100001;
`else
        exp_r = 32'h40100000;
`endif
        run_op(32'h3FC00001, 32'h3FC00000, res, o, u, cyc);
        n_checks++;
        if (res !== exp_r || {o, u} !== 2'b00) begin
            n_fail++;
            $display("FAIL rounding: got %h of/uf=%b required %h 00", res, {o, u}, exp_r);
        end
        run_op(32'h3FFFFFFF, 32'h3FFFFFFF, res, o, u, cyc);
        n_checks++;
        if (res !== 32'h407FFFFE) begin
            n_fail++;
            $display("FAIL norm_shift: got %h required 407FFFFE", res);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        @(negedge clk);
        in_a  = 32'h3F800000;
        in_b  = 32'h4EA0C8E4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %b required 1", busy);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 5) begin
                start = 1'b1;
                in_a  = 32'hC3818000;
                in_b  = 32'hC3818000;
            end
            if (cyc == 7) start = 1'b0;
        end
        n_checks++;
        if (result !== 32'h4EA0C8E4 || cyc != 27) begin
            n_fail++;
            $display("FAIL ignore_start: got %h after %0d cycles required 4EA0C8E4 after 27", result, cyc);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done/busy=%b%b required 00", done, busy);
        end
    endtask

    task automatic test_hold;
        in_a = 32'h12345678;
        in_b = 32'h9ABCDEF0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (result !== 32'h4EA0C8E4 || {of, uf} !== 2'b00 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL hold: got %h of/uf=%b done=%b required 4EA0C8E4 00 0", result, {of, uf}, done);
        end
    endtask

    task automatic test_reset_midop;
        logic [31:0] res;
        logic        o, u;
        int          cyc;
        run_op(32'h7F7FFFF0, 32'h41A00000, res, o, u, cyc);
        @(negedge clk);
        in_a  = 32'hC3818000;
        in_b  = 32'hC3818000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, of, uf} !== 4'b0000 || result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_midop: busy/done/of/uf=%b result=%h required 0000 00000000",
                     {busy, done, of, uf}, result);
        end
        @(negedge clk);
        reset = 1'b0;
        run_op(32'hC3818000, 32'hC3818000, res, o, u, cyc);
        n_checks++;
        if (res !== 32'h47830480 || {o, u} !== 2'b00 || cyc != 27) begin
            n_fail++;
            $display("FAIL after_reset: got %h of/uf=%b in %0d cycles required 47830480 00 in 27",
                     res, {o, u}, cyc);
        end
    endtask

    task automatic test_half;
        int cyc;
        @(negedge clk);
        h_a     = 16'h3C00;
        h_b     = 16'h4000;
        h_start = 1'b1;
        @(posedge clk);
        #1;
        h_start = 1'b0;
        cyc     = 0;
        while (h_done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_checks++;
        if (h_result !== 16'h4000 || {h_of, h_uf} !== 2'b00) begin
            n_fail++;
            $display("FAIL half_result: got %h of/uf=%b required 4000 00", h_result, {h_of, h_uf});
        end
        n_checks++;
        if (cyc != 14) begin
            n_fail++;
            $display("FAIL half_latency: got %0d cycles required 14", cyc);
        end
    endtask

    initial begin
        clk      = 1'b0;
        reset    = 1'b1;
        start    = 1'b0;
        in_a     = '0;
        in_b     = '0;
        h_start  = 1'b0;
        h_a      = '0;
        h_b      = '0;
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_vectors();
        test_rounding();
        test_back_to_back();
        test_hold();
        test_reset_midop();
        test_half();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
